// File: rtl/instr_encoder_loader_if.sv
// Field-tuple handshake and instruction-memory write port of the instruction encoder/loader.
// The loader uses the slave view; the field source / memory side uses the master view.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              fld_valid;
    logic              fld_ready;
    logic              fmt;
    logic [4:0]        opcode;
    logic [4:0]        dir_write;
    logic [4:0]        dir_reg_a;
    logic [4:0]        dir_reg_b;
    logic [15:0]       inm;
    logic              imem_stall;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  fld_valid, fmt, opcode, dir_write, dir_reg_a, dir_reg_b, inm, imem_stall,
        output fld_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output fld_valid, fmt, opcode, dir_write, dir_reg_a, dir_reg_b, inm, imem_stall,
        input  fld_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into 32-bit words and streams them into instruction memory from a
// base address through a small FIFO. Define PACK_CHECK_EN to replace illegal opcodes with NOPs.
module instr_encoder_loader #(
    parameter int ADDR_W      = 10,
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_OPCODES = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     len,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            err_cnt,
    instr_encoder_loader_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (NUM_OPCODES < 1 || NUM_OPCODES > 32) begin : g_bad_num_opcodes
        $error("NUM_OPCODES must lie in 1..32");
    end

    function automatic logic [31:0] pack_fields(
        input logic        f,
        input logic [4:0]  op,
        input logic [4:0]  wr,
        input logic [4:0]  ra,
        input logic [4:0]  rb,
        input logic [15:0] imm
    );
        if (f) pack_fields = {op, wr, ra, 1'b0, imm};
        else   pack_fields = {op, wr, ra, rb, 12'h000};
    endfunction

    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] base_q,       base_d;
    logic [ADDR_W-1:0] len_q,        len_d;
    logic [ADDR_W-1:0] acc_cnt_q,    acc_cnt_d;
    logic [ADDR_W-1:0] wr_cnt_q,     wr_cnt_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [CNT_W-1:0]  count_q,      count_d;
    logic              imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];
    logic [31:0]       fifo_mem_d [FIFO_DEPTH];

    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic [31:0] packed_word;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // A full FIFO refuses new tuples even when a pop happens in the same cycle.
    assign bus.fld_ready = (state_q == ST_LOAD) && !fifo_full && (acc_cnt_q < len_q);
    assign push          = bus.fld_valid && bus.fld_ready;
    assign pop           = (state_q == ST_LOAD) && !fifo_empty && !bus.imem_stall;

`ifdef PACK_CHECK_EN
    logic       opc_illegal;
    logic [7:0] err_cnt_q, err_cnt_d;

    assign opc_illegal = (int'(bus.opcode) >= NUM_OPCODES);
    assign packed_word = opc_illegal ? 32'h0000_0000
                       : pack_fields(bus.fmt, bus.opcode, bus.dir_write, bus.dir_reg_a,
                                     bus.dir_reg_b, bus.inm);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == ST_IDLE && start) begin
            err_cnt_d = 8'h00;
        end else if (push && opc_illegal && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_cnt_q <= 8'h00;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign packed_word = pack_fields(bus.fmt, bus.opcode, bus.dir_write, bus.dir_reg_a,
                                     bus.dir_reg_b, bus.inm);
    assign err_cnt     = 8'h00;
`endif

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        acc_cnt_d    = acc_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        fifo_mem_d   = fifo_mem_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    len_d     = len;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                    state_d   = (len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // The strobe of the final word is on the bus now; finish after it.
                if (imem_we_q && wr_cnt_q == len_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (push) begin
            fifo_mem_d[wr_ptr_q] = packed_word;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            acc_cnt_d            = acc_cnt_q + ADDR_W'(1);
        end

        if (pop) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = base_q + wr_cnt_q;
            imem_wdata_d = fifo_mem_q[rd_ptr_q];
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            wr_cnt_d     = wr_cnt_q + ADDR_W'(1);
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            acc_cnt_q    <= '0;
            wr_cnt_q     <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            acc_cnt_q    <= acc_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
        fifo_mem_q <= fifo_mem_d;
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);

endmodule
